// File: rtl/riscy_trace_pkg.sv
// ---------------------------------------------------------------------------
// riscy_trace_pkg
// Shared constants for the instruction trace capture block.
//   TRACE_REC_W        : width of one stored trace record (64, or 96 with
//                        INSTR_TRACE_TIMESTAMP_EN defined)
//   PC_LSB / INSTR_LSB : field offsets of PC and instruction inside a record
//   TS_LSB             : field offset of the timestamp (timestamp builds only)
//   DROP_CNT_W         : width of the saturating dropped-capture counter
//   EXEC_STATE_DEFAULT : core FSM encoding of the execute state
//   sat_inc()          : saturating increment used by the drop counter
// ---------------------------------------------------------------------------
package riscy_trace_pkg;

    localparam int PC_LSB    = 0;
    localparam int INSTR_LSB = 32;

`ifdef INSTR_TRACE_TIMESTAMP_EN
    localparam int TS_LSB      = 64;
    localparam int TRACE_REC_W = 96;
`else
    localparam int TRACE_REC_W = 64;
`endif

    localparam int DROP_CNT_W         = 16;
    localparam int EXEC_STATE_DEFAULT = 3;

    // Counts up and sticks at all-ones instead of wrapping back to zero.
    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (v == '1) ? v : v + DROP_CNT_W'(1);
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// ---------------------------------------------------------------------------
// trace_fifo
// Generic synchronous first-word-fall-through FIFO. The head entry is
// presented on dout combinationally from storage at the read pointer.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write request and data (ignored when full unless popping)
//   pop        : read request (ignored when empty)
//   dout       : head entry; stale contents when empty
//   level      : occupancy, 0..DEPTH
//   full/empty : occupancy flags
// ---------------------------------------------------------------------------
module trace_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [LVL_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    // Occupancy is kept separately from the pointers, so equal pointers
    // never leave full and empty ambiguous.
    assign full  = (count == LVL_W'(DEPTH));
    assign empty = (count == '0);

    // A push into a full FIFO is still legal when the head leaves the
    // same cycle; a pop from an empty FIFO is never legal.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Storage is cleared on reset so the stale head reads as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + LVL_W'(1);
                2'b01:   count <= count - LVL_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign level = count;

endmodule

// File: rtl/instr_trace_capture.sv
// ---------------------------------------------------------------------------
// instr_trace_capture
// Watches the SOC debug taps and captures one {PC, INSTR} record each time
// the core FSM enters the execute state. Records drain in capture order
// over a valid/ready interface; captures arriving while full are dropped
// and counted.
// Optional feature macro: INSTR_TRACE_TIMESTAMP_EN adds a free-running
// 32-bit cycle counter, stores its value with each record and exposes it
// on out_ts.
//   CLK, RESET          : clock, asynchronous active-low reset
//   enable              : capture enable (draining continues when low)
//   state_in            : core FSM state
//   pc_in, instr_in     : core PC and instruction, sampled at the trigger
//   out_valid/out_ready : record handshake
//   out_pc, out_instr   : head record fields
//   out_ts              : head record timestamp (timestamp builds only)
//   level               : FIFO occupancy
//   overflow            : sticky, set when any capture is dropped
//   drop_cnt            : saturating dropped-capture count
// ---------------------------------------------------------------------------
module instr_trace_capture
    import riscy_trace_pkg::*;
#(
    parameter int                 DEPTH      = 8,
    parameter int                 STATE_W    = 3,
    parameter logic [STATE_W-1:0] EXEC_STATE = STATE_W'(EXEC_STATE_DEFAULT)
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    enable,
    input  logic [STATE_W-1:0]      state_in,
    input  logic [31:0]             pc_in,
    input  logic [31:0]             instr_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_pc,
    output logic [31:0]             out_instr,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    overflow,
    output logic [DROP_CNT_W-1:0]   drop_cnt
`ifdef INSTR_TRACE_TIMESTAMP_EN
    ,
    output logic [31:0]             out_ts
`endif
);

    logic [STATE_W-1:0]     prev_state;
    logic                   cap;
    logic                   pop_req;
    logic                   fifo_push;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   drop;
    logic [TRACE_REC_W-1:0] rec_in;
    logic [TRACE_REC_W-1:0] rec_out;

    // prev_state follows the bus regardless of enable, so raising enable in
    // the middle of an execute run never produces a late capture.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            prev_state <= '0;
        end else begin
            prev_state <= state_in;
        end
    end

    assign cap       = enable && (state_in == EXEC_STATE) && (prev_state != EXEC_STATE);
    assign pop_req   = out_valid && out_ready;
    assign fifo_push = cap && (!fifo_full || pop_req);
    assign drop      = cap && fifo_full && !pop_req;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            drop_cnt <= sat_inc(drop_cnt);
        end
    end

`ifdef INSTR_TRACE_TIMESTAMP_EN
    logic [31:0] cycle_cnt;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            cycle_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end
`endif

    always_comb begin
        rec_in                     = '0;
        rec_in[PC_LSB +: 32]       = pc_in;
        rec_in[INSTR_LSB +: 32]    = instr_in;
`ifdef INSTR_TRACE_TIMESTAMP_EN
        rec_in[TS_LSB +: 32]       = cycle_cnt;
`endif
    end

    trace_fifo #(
        .WIDTH (TRACE_REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RESET),
        .push  (fifo_push),
        .pop   (pop_req),
        .din   (rec_in),
        .dout  (rec_out),
        .level (level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign out_pc    = rec_out[PC_LSB +: 32];
    assign out_instr = rec_out[INSTR_LSB +: 32];
`ifdef INSTR_TRACE_TIMESTAMP_EN
    assign out_ts    = rec_out[TS_LSB +: 32];
`endif

endmodule

// File: tb/tb_instr_trace_capture.sv
// ---------------------------------------------------------------------------
// tb_instr_trace_capture
// Directed vector table, hand-written corner sequences and randomized
// traffic against a queue-based reference model of the trace capture.
// ---------------------------------------------------------------------------
module tb_instr_trace_capture;

    localparam int DEPTH = 8;
    localparam int EXEC  = 3;

    logic        CLK;
    logic        RESET;
    logic        enable;
    logic [2:0]  state_in;
    logic [31:0] pc_in;
    logic [31:0] instr_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [3:0]  level;
    logic        overflow;
    logic [15:0] drop_cnt;
`ifdef INSTR_TRACE_TIMESTAMP_EN
    logic [31:0] out_ts;
`endif

    instr_trace_capture #(
        .DEPTH      (DEPTH),
        .STATE_W    (3),
        .EXEC_STATE (3'd3)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .enable    (enable),
        .state_in  (state_in),
        .pc_in     (pc_in),
        .instr_in  (instr_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .level     (level),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
`ifdef INSTR_TRACE_TIMESTAMP_EN
        ,
        .out_ts    (out_ts)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int vec_count;
    int miss_count;

    // Reference model: an ordered list of {instr, pc} records plus the
    // observed previous state and drop bookkeeping.
    logic [63:0] mq[$];
    int          m_prev;
    bit          m_ovf;
    int          m_drop;

    typedef struct {
        bit          en;
        int          st;
        logic [31:0] pc;
        bit          rdy;
        bit          ev;
        int          el;
        logic [31:0] epc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mkv(bit en, int st, logic [31:0] pc, bit rdy,
                                 bit ev, int el, logic [31:0] epc);
        vec_t t;
        t.en = en; t.st = st; t.pc = pc; t.rdy = rdy;
        t.ev = ev; t.el = el; t.epc = epc;
        return t;
    endfunction

    function automatic logic [31:0] instrOf(input logic [31:0] pc);
        return pc + 32'h3;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_count++;
        if (act !== exp) begin
            miss_count++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        mq.delete();
        m_prev = 0;
        m_ovf  = 0;
        m_drop = 0;
    endtask

    task automatic modelStep(input bit en, input int st, input logic [31:0] pc,
                             input logic [31:0] instr, input bit rdy);
        bit capture;
        bit pop;
        bit was_full;
        capture  = en && (st == EXEC) && (m_prev != EXEC);
        pop      = (mq.size() > 0) && rdy;
        was_full = (mq.size() == DEPTH);
        if (pop) void'(mq.pop_front());
        if (capture) begin
            if (!was_full || pop) begin
                mq.push_back({instr, pc});
            end else begin
                m_ovf = 1;
                if (m_drop < 65535) m_drop++;
            end
        end
        m_prev = st;
    endtask

    task automatic applyStimulus(input bit en, input int st, input logic [31:0] pc,
                                 input logic [31:0] instr, input bit rdy);
        @(negedge CLK);
        enable    = en;
        state_in  = 3'(st);
        pc_in     = pc;
        instr_in  = instr;
        out_ready = rdy;
        modelStep(en, st, pc, instr, rdy);
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string tag);
        check({tag, ".valid"}, 32'(out_valid), 32'(mq.size() > 0));
        check({tag, ".level"}, 32'(level), 32'(mq.size()));
        check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
        check({tag, ".drop_cnt"}, 32'(drop_cnt), 32'(m_drop));
        if (mq.size() > 0) begin
            check({tag, ".pc"}, out_pc, mq[0][31:0]);
            check({tag, ".instr"}, out_instr, mq[0][63:32]);
        end
    endtask

    task automatic doReset();
        @(negedge CLK);
        RESET     = 1'b0;
        enable    = 1'b1;
        state_in  = 3'd0;
        pc_in     = '0;
        instr_in  = '0;
        out_ready = 1'b0;
        #1;
        check("reset.valid", 32'(out_valid), 32'd0);
        check("reset.level", 32'(level), 32'd0);
        check("reset.overflow", 32'(overflow), 32'd0);
        check("reset.drop_cnt", 32'(drop_cnt), 32'd0);
        check("reset.pc", out_pc, 32'd0);
        check("reset.instr", out_instr, 32'd0);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        modelReset();
    endtask

    initial begin
        vec_count  = 0;
        miss_count = 0;
        RESET      = 1'b1;
        enable     = 1'b1;
        state_in   = 3'd0;
        pc_in      = '0;
        instr_in   = '0;
        out_ready  = 1'b0;
        modelReset();

        // Directed table: idle, single capture, backpressure/order,
        // simultaneous push+pop on empty, enable gating.
        tbl.push_back(mkv(1, 1, 32'h0,   0, 0, 0, 32'h0));
        tbl.push_back(mkv(1, 2, 32'h0,   0, 0, 0, 32'h0));
        tbl.push_back(mkv(1, 1, 32'h0,   0, 0, 0, 32'h0));
        tbl.push_back(mkv(1, 2, 32'h0,   0, 0, 0, 32'h0));
        tbl.push_back(mkv(1, 3, 32'h10,  0, 1, 1, 32'h10));
        tbl.push_back(mkv(1, 3, 32'h20,  0, 1, 1, 32'h10));
        tbl.push_back(mkv(1, 3, 32'h30,  0, 1, 1, 32'h10));
        tbl.push_back(mkv(1, 3, 32'h40,  0, 1, 1, 32'h10));
        tbl.push_back(mkv(1, 2, 32'h0,   1, 0, 0, 32'h0));
        tbl.push_back(mkv(1, 3, 32'h0,   0, 1, 1, 32'h0));
        tbl.push_back(mkv(1, 2, 32'h0,   0, 1, 1, 32'h0));
        tbl.push_back(mkv(1, 3, 32'h4,   0, 1, 2, 32'h0));
        tbl.push_back(mkv(1, 2, 32'h0,   0, 1, 2, 32'h0));
        tbl.push_back(mkv(1, 3, 32'h8,   0, 1, 3, 32'h0));
        tbl.push_back(mkv(1, 2, 32'h0,   0, 1, 3, 32'h0));
        tbl.push_back(mkv(1, 3, 32'hC,   0, 1, 4, 32'h0));
        tbl.push_back(mkv(1, 2, 32'h0,   1, 1, 3, 32'h4));
        tbl.push_back(mkv(1, 2, 32'h0,   1, 1, 2, 32'h8));
        tbl.push_back(mkv(1, 2, 32'h0,   1, 1, 1, 32'hC));
        tbl.push_back(mkv(1, 2, 32'h0,   1, 0, 0, 32'h0));
        tbl.push_back(mkv(1, 3, 32'h100, 1, 1, 1, 32'h100));
        tbl.push_back(mkv(1, 2, 32'h0,   1, 0, 0, 32'h0));
        tbl.push_back(mkv(0, 3, 32'h200, 0, 0, 0, 32'h0));
        tbl.push_back(mkv(1, 3, 32'h204, 0, 0, 0, 32'h0));
        tbl.push_back(mkv(1, 2, 32'h0,   0, 0, 0, 32'h0));
        tbl.push_back(mkv(0, 3, 32'h208, 0, 0, 0, 32'h0));

        doReset();
        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i].en, tbl[i].st, tbl[i].pc, instrOf(tbl[i].pc), tbl[i].rdy);
            check($sformatf("tbl%0d.valid", i), 32'(out_valid), 32'(tbl[i].ev));
            check($sformatf("tbl%0d.level", i), 32'(level), 32'(tbl[i].el));
            check($sformatf("tbl%0d.overflow", i), 32'(overflow), 32'd0);
            if (tbl[i].ev) begin
                check($sformatf("tbl%0d.pc", i), out_pc, tbl[i].epc);
                check($sformatf("tbl%0d.instr", i), out_instr, instrOf(tbl[i].epc));
            end
        end

        // Overflow: ten triggers with no consumer into an 8-deep FIFO.
        doReset();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 3, 32'(i * 4), instrOf(32'(i * 4)), 0);
            checkOutput("ovf.trig");
            applyStimulus(1, 2, 32'h0, 32'h0, 0);
        end
        check("ovf.level", 32'(level), 32'd8);
        check("ovf.overflow", 32'(overflow), 32'd1);
        check("ovf.drop_cnt", 32'(drop_cnt), 32'd2);
        check("ovf.head", out_pc, 32'h0);

        // Full with a trigger and a pop in the same cycle: both succeed.
        applyStimulus(1, 3, 32'h200, instrOf(32'h200), 1);
        checkOutput("fullpop");
        check("fullpop.level", 32'(level), 32'd8);
        check("fullpop.drop_cnt", 32'(drop_cnt), 32'd2);
        check("fullpop.head", out_pc, 32'h4);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain%0d.pc", i), out_pc, (i < 7) ? 32'((i + 1) * 4) : 32'h200);
            applyStimulus(1, 2, 32'h0, 32'h0, 1);
            checkOutput("drain");
        end
        check("drain.valid", 32'(out_valid), 32'd0);
        check("drain.overflow", 32'(overflow), 32'd1);

        // Reset mid-drain, asserted between clock edges, then enable gating.
        doReset();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 3, 32'(32'h300 + i * 4), instrOf(32'(32'h300 + i * 4)), 0);
            applyStimulus(1, 2, 32'h0, 32'h0, 0);
        end
        check("midrst.level_before", 32'(level), 32'd5);
        out_ready = 1'b1;
        enable    = 1'b0;
        #2;
        RESET = 1'b0;
        #1;
        check("midrst.level", 32'(level), 32'd0);
        check("midrst.valid", 32'(out_valid), 32'd0);
        @(negedge CLK);
        state_in = 3'd0;
        RESET    = 1'b1;
        modelReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 3, 32'h400, instrOf(32'h400), 0);
            applyStimulus(0, 2, 32'h0, 32'h0, 0);
            checkOutput("gated");
        end
        check("gated.level", 32'(level), 32'd0);

        // Randomized traffic against the reference model.
        doReset();
        for (int i = 0; i < 1500; i++) begin
            int r;
            int st;
            r  = int'($urandom_range(0, 9));
            st = (r < 4) ? 3 : (r < 8) ? 2 : (r - 8);
            applyStimulus($urandom_range(0, 7) != 0, st, $urandom, $urandom,
                          $urandom_range(0, 2) == 0);
            checkOutput("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
